exe_div_unit: RTL and testbench
===============================

// Module: exe_div_unit
// PURPOSE
//  Multi-cycle RV32M divide/remainder unit in the EXE stage. Fed directly by the
//  ID/EXE pipeline register: exe_div_valid, exe_div_op, exe_fwdopA, exe_fwdopB.
//  Radix-2 restoring divider, one quotient bit per cycle.
//  Raises div_stall to freeze IF/ID/EXE until the result is ready, then drives
//  div_result into the EXE result mux.
// PARAMETERS
//  WIDTH      32  operand/result width (only 32 is supported)
//  CNT_BITS    6  iteration counter width (must hold WIDTH)
// PORTS
//  clk         in   1      clock, rising edge
//  nrst        in   1      asynchronous active-low reset
//  flush       in   1      pipeline flush of the EXE instruction; aborts any operation
//  div_valid   in   1      EXE holds a DIV/DIVU/REM/REMU (from exe_div_valid)
//  div_op      in   2      00 DIV, 01 DIVU, 10 REM, 11 REMU
//  opA         in   WIDTH  dividend (rs1, forwarded)
//  opB         in   WIDTH  divisor (rs2, forwarded)
//  div_result  out  WIDTH  quotient or remainder; valid only while div_done=1
//  div_done    out  1      result valid this cycle (DONE state)
//  div_stall   out  1      combinational: div_valid & ~div_done & ~flush
//  div_busy    out  1      state==RUN
// BEHAVIOUR
//  Reset: state=IDLE. div_result=0, div_done=0, div_busy=0.
//   Quotient, remainder, divisor, counter and sign flags all clear to 0.
//  States: IDLE, RUN, DONE.
//  - IDLE and div_valid & ~flush, at cycle T: latch operands and operation.
//    - opB==0: next state DONE (special case).
//    - DIV/REM with opA==32'h8000_0000 and opB==32'hFFFF_FFFF: next state DONE (overflow).
//    - otherwise: next state RUN, counter=0.
//  - Operand setup: DIV/REM use |opA| and |opB|. Record neg_q = sA^sB and neg_r = sA.
//    DIVU/REMU use raw operands with neg_q = neg_r = 0.
//  - RUN, one step per cycle:
//    - rem' = {rem[30:0], dvd[31]}; dvd <<= 1.
//    - If rem' >= dsr: rem' -= dsr and the new q bit = 1, else the q bit = 0.
//    - After 32 steps (counter==31) go to DONE.
//  - DONE lasts exactly 1 cycle; div_done=1, then IDLE unconditionally.
//    - Normal result: DIV/DIVU = neg_q ? -q : q. REM/REMU = neg_r ? -r : r.
//    - Divide by zero: DIV/DIVU = 32'hFFFF_FFFF; REM/REMU = opA.
//    - Overflow: DIV = 32'h8000_0000; REM = 0.
//  Latency: normal op has div_done at T+33; special cases at T+1.
//   div_stall is high from T through T+32 and low in the DONE cycle,
//   so the pipeline advances after DONE.
//  Back-to-back divides: the next div is seen in IDLE at T+34 and starts then.
//   It never restarts off the same instruction, because DONE always moves to IDLE.
//  flush (any state): next state IDLE, div_done=0, div_stall=0, no result.
//  div_valid dropping during RUN (not expected): operation completes anyway,
//   and div_done still pulses.
//  nrst low mid-operation: immediate return to the reset values; no result pulse.
//  Arithmetic: negation is two's complement mod 2^32. rem is 32 bits, and the
//   compare uses the 33-bit difference {1'b0,rem'} - {1'b0,dsr}.
// TESTING
//  1 DIV 100/7 at T -> div_stall high T..T+32; at T+33 div_done=1, result=14.
//  2 REM -7 (FFFF_FFF9) by 2 -> result FFFF_FFFF (-1). DIV -7/2 -> FFFF_FFFD (-3).
//  3 DIVU FFFF_FFFF/1 -> FFFF_FFFF. REMU FFFF_FFFF/10 -> 5. Both at T+33.
//  4 DIV 5/0 -> FFFF_FFFF at T+1. REMU 1234/0 -> 1234 at T+1. div_busy never set.
//  5 DIV 8000_0000/FFFF_FFFF -> 8000_0000 at T+1; REM same operands -> 0.
//  6 Start DIV 100/7, assert flush at T+10 -> IDLE at T+11, no div_done.
//     Pulse nrst low at T+5 of a second run -> outputs 0 immediately.
//     Then a new DIV 9/3 -> result 3 at its start+33.

Source files
------------

// File: rtl/exe_div_if.sv
// Interface between the EXE stage and the divide unit.
//   master : pipeline side; drives flush, div_valid, div_op, opA, opB
//   slave  : divide unit; drives div_result, div_done, div_stall, div_busy
interface exe_div_if #(
  parameter int unsigned WIDTH = 32
);
  logic             flush;
  logic             div_valid;
  logic [1:0]       div_op;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] div_result;
  logic             div_done;
  logic             div_stall;
  logic             div_busy;

  modport master (
    output flush, div_valid, div_op, opA, opB,
    input  div_result, div_done, div_stall, div_busy
  );

  modport slave (
    input  flush, div_valid, div_op, opA, opB,
    output div_result, div_done, div_stall, div_busy
  );
endinterface

// File: rtl/exe_div_unit.sv
// Multi-cycle RV32M divide/remainder unit (DIV/DIVU/REM/REMU) for the EXE stage.
// Radix-2 restoring divider producing one quotient bit per cycle.
// Ports:
//   clk   : clock, rising edge
//   nrst  : asynchronous active-low reset
//   bus   : exe_div_if.slave
//           flush, div_valid, div_op (00 DIV, 01 DIVU, 10 REM, 11 REMU), opA, opB in;
//           div_result (valid while div_done), div_done, div_stall, div_busy out
module exe_div_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CNT_BITS = 6
) (
  input  logic     clk,
  input  logic     nrst,
  exe_div_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [WIDTH-1:0] IntMin = {1'b1, {(WIDTH-1){1'b0}}};

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    dvd_q, dvd_d;   // shifting dividend magnitude
  logic [WIDTH-1:0]    quo_q, quo_d;
  logic [WIDTH-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0]    dsr_q, dsr_d;   // divisor magnitude
  logic [WIDTH-1:0]    opa_q, opa_d;   // raw dividend, returned by REM on divide-by-zero
  logic [1:0]          op_q, op_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                negq_q, negq_d;
  logic                negr_q, negr_d;
  logic                dz_q, dz_d;
  logic                ovf_q, ovf_d;

  logic             is_signed;
  logic             s_a, s_b;
  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH:0]   diff;
  logic             done;

  assign is_signed = ~bus.div_op[0];
  assign s_a       = is_signed & bus.opA[WIDTH-1];
  assign s_b       = is_signed & bus.opB[WIDTH-1];
  assign rem_sh    = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
  assign diff      = {1'b0, rem_sh} - {1'b0, dsr_q};

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    opa_d   = opa_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (bus.div_valid && !bus.flush) begin
          op_d   = bus.div_op;
          opa_d  = bus.opA;
          dvd_d  = s_a ? -bus.opA : bus.opA;
          dsr_d  = s_b ? -bus.opB : bus.opB;
          negq_d = s_a ^ s_b;
          negr_d = s_a;
          quo_d  = '0;
          rem_d  = '0;
          cnt_d  = '0;
          dz_d   = (bus.opB == '0);
          ovf_d  = is_signed && (bus.opA == IntMin) && (bus.opB == '1);
          state_d = ((bus.opB == '0) ||
                     (is_signed && (bus.opA == IntMin) && (bus.opB == '1))) ? StDone : StRun;
        end
      end
      StRun: begin
        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh;
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_BITS'(WIDTH - 1)) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (bus.flush) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= StIdle;
      dvd_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
      opa_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dsr_q   <= dsr_d;
      opa_q   <= opa_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  // A flush in the DONE cycle suppresses the result.
  assign done = (state_q == StDone) && !bus.flush;

  always_comb begin
    bus.div_result = '0;
    if (done) begin
      if (dz_q) begin
        bus.div_result = op_q[1] ? opa_q : '1;
      end else if (ovf_q) begin
        bus.div_result = op_q[1] ? '0 : IntMin;
      end else if (op_q[1]) begin
        bus.div_result = negr_q ? -rem_q : rem_q;
      end else begin
        bus.div_result = negq_q ? -quo_q : quo_q;
      end
    end
  end

  assign bus.div_done  = done;
  assign bus.div_busy  = (state_q == StRun);
  assign bus.div_stall = bus.div_valid & ~done & ~bus.flush;

endmodule

// File: tb/tb_exe_div_unit.sv
// Self-checking bench for exe_div_unit: directed vectors, a transaction-level
// arithmetic model, and a per-cycle compare process.
module tb_exe_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic nrst = 1'b1;

  exe_div_if #(.WIDTH(W)) bus ();

  exe_div_unit #(.WIDTH(W), .CNT_BITS(6)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Model of the in-flight operation.
  bit          active = 1'b0;
  int          t_start = 0;
  int          lat = 0;
  int          end_cyc = 0;
  logic [31:0] exp_res = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'h0 : 32'h8000_0000;
    case (op)
      2'b00:   return 32'(sa / sb);
      2'b01:   return a / b;
      2'b10:   return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (nrst === 1'b1) begin
      bit e_done, e_busy, e_stall;
      e_done  = active && (cyc == t_start + lat) && (cyc < end_cyc);
      e_busy  = active && (lat == 33) && (cyc >= t_start + 1) && (cyc <= t_start + 32) &&
                (cyc <= end_cyc);
      e_stall = bus.div_valid && !e_done && !bus.flush;
      check("div_done", 32'(bus.div_done), 32'(e_done));
      check("div_busy", 32'(bus.div_busy), 32'(e_busy));
      check("div_stall", 32'(bus.div_stall), 32'(e_stall));
      if (e_done) check("div_result", bus.div_result, exp_res);
    end
  end

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int flush_at);
    @(posedge clk); #1;
    bus.div_valid = 1'b1;
    bus.div_op    = op;
    bus.opA       = a;
    bus.opB       = b;
    exp_res = model(op, a, b);
    lat     = is_special(op, a, b) ? 1 : 33;
    t_start = cyc;
    end_cyc = (flush_at < 0) ? (1 << 30) : (t_start + flush_at);
    active  = 1'b1;
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] lit);
    start_op(op, a, b, -1);
    while (cyc < t_start + lat) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check({name, "_done"}, 32'(bus.div_done), 32'd1);
    check({name, "_lit"}, bus.div_result, lit);
    if (lat == 1) check({name, "_nobusy"}, 32'(bus.div_busy), 32'd0);
    @(posedge clk); #1;
    bus.div_valid = 1'b0;
    active = 1'b0;
  endtask

  initial begin
    bus.flush = 1'b0;
    bus.div_valid = 1'b0;
    bus.div_op = 2'b00;
    bus.opA = '0;
    bus.opB = '0;
    #1 nrst = 1'b0;
    #2;
    check("rst_done", 32'(bus.div_done), 32'd0);
    check("rst_busy", 32'(bus.div_busy), 32'd0);
    check("rst_result", bus.div_result, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) nrst = 1'b1;

    run_op("div_100_7", 2'b00, 32'd100, 32'd7, 32'd14);
    run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
    run_op("remu_max_10", 2'b11, 32'hFFFF_FFFF, 32'd10, 32'd5);
    run_op("div_5_0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_op("remu_1234_0", 2'b11, 32'd1234, 32'd0, 32'd1234);
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    run_op("rem_100_m7", 2'b10, 32'd100, 32'hFFFF_FFF9, 32'd2);
    run_op("div_m100_m7", 2'b00, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14);
    run_op("divu_min_max", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    // Flush at T+10 aborts the operation.
    start_op(2'b00, 32'd100, 32'd7, 10);
    while (cyc < end_cyc) begin
      @(posedge clk); #1;
    end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.div_valid = 1'b0;
    active = 1'b0;
    @(negedge clk);
    check("flush_idle_busy", 32'(bus.div_busy), 32'd0);
    check("flush_idle_done", 32'(bus.div_done), 32'd0);
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("flush_no_late_done", 32'(bus.div_done), 32'd0);

    // Asynchronous reset at T+5 mid-operation.
    start_op(2'b00, 32'd100, 32'd7, -1);
    repeat (5) @(posedge clk);
    #1;
    nrst = 1'b0;
    bus.div_valid = 1'b0;
    active = 1'b0;
    #1;
    check("arst_busy", 32'(bus.div_busy), 32'd0);
    check("arst_done", 32'(bus.div_done), 32'd0);
    check("arst_result", bus.div_result, 32'd0);
    check("arst_stall", 32'(bus.div_stall), 32'd0);
    @(negedge clk) nrst = 1'b1;

    run_op("div_9_3", 2'b00, 32'd9, 32'd3, 32'd3);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
